// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch path: datapath width,
// fetch FSM state encoding and the buffered {instruction, address} entry.
package instr_fetch_pkg;

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {instruction, address} pairs.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write an entry (accepted when full only alongside a pop)
//   pop               remove the head (ignored when empty)
//   flush             empty the buffer; wins over push and pop
//   count             number of valid entries
//   head              oldest entry, combinational
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_pop;
    logic             do_push;

    // Pointer advance with wrap, so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks a fetch pointer through memory, buffers the
// returned words and hands them to the decoder, reporting PC updates.
// Ports:
//   c_CLOCK, c_RESET            clock, asynchronous active-high reset
//   i_PC, f_FLUSH               redirect target and redirect strobe
//   o_MEMADDR, o_MEMREQ         memory read request (held until i_MEMACK)
//   i_MEMACK, i_MEMDATA         memory response
//   o_INSTR, o_VALID, i_TAKE    head instruction handshake with the decoder
//   o_PCDATA, o_PCWRITE         next-PC writeback after each consumed word
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            c_CLOCK,
    input  logic            c_RESET,
    input  logic [XLEN-1:0] i_PC,
    input  logic            f_FLUSH,
    output logic [XLEN-1:0] o_MEMADDR,
    output logic            o_MEMREQ,
    input  logic            i_MEMACK,
    input  logic [XLEN-1:0] i_MEMDATA,
    output logic [XLEN-1:0] o_INSTR,
    output logic            o_VALID,
    input  logic            i_TAKE,
    output logic [XLEN-1:0] o_PCDATA,
    output logic            o_PCWRITE
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q;
    fetch_state_e    state_n;
    logic [XLEN-1:0] fpc_q;
    logic [XLEN-1:0] fpc_n;
    logic [XLEN-1:0] memaddr_q;
    logic            memreq_q;
    logic [XLEN-1:0] pcdata_q;
    logic            pcwrite_q;
    logic            push;
    logic            pop;
    logic            room_after_push;
    logic [CNT_W-1:0] count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (c_CLOCK),
        .rst       (c_RESET),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (f_FLUSH),
        .count     (count),
        .head      (head)
    );

    assign o_VALID    = (count != '0);
    assign o_INSTR    = head.instr;
    assign pop        = i_TAKE && o_VALID;
    assign push_entry = '{instr: i_MEMDATA, addr: fpc_q};

    // In REQ the buffer is never full, so count + 1 cannot overflow CNT_W.
    assign room_after_push = pop || ((count + CNT_W'(1)) < CNT_W'(DEPTH));

    // Next-state and fetch-pointer logic.
    always_comb begin
        state_n = state_q;
        fpc_n   = fpc_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_FLUSH) begin
                    fpc_n = i_PC;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (f_FLUSH) begin
                    fpc_n   = i_PC;
                    state_n = i_MEMACK ? IDLE : DRAIN;
                end else if (i_MEMACK) begin
                    push    = 1'b1;
                    fpc_n   = fpc_q + XLEN'(1);
                    state_n = room_after_push ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // Outstanding read completes and is dropped; a new redirect
                // only retargets the pointer.
                if (f_FLUSH) begin
                    fpc_n = i_PC;
                end
                if (i_MEMACK) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, pointer and memory request registers. The request address is
    // captured only on entry to / continuation of REQ, so DRAIN keeps the
    // address of the abandoned read.
    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            state_q   <= IDLE;
            fpc_q     <= '0;
            memreq_q  <= 1'b0;
            memaddr_q <= '0;
        end else begin
            state_q  <= state_n;
            fpc_q    <= fpc_n;
            memreq_q <= (state_n != IDLE);
            if (state_n == REQ) begin
                memaddr_q <= fpc_n;
            end
        end
    end

    // PC writeback pulse after each consumed word; a redirect cancels it.
    always_ff @(posedge c_CLOCK or posedge c_RESET) begin
        if (c_RESET) begin
            pcwrite_q <= 1'b0;
            pcdata_q  <= '0;
        end else begin
            pcwrite_q <= pop && !f_FLUSH;
            if (pop && !f_FLUSH) begin
                pcdata_q <= head.addr + XLEN'(1);
            end
        end
    end

    assign o_MEMADDR = memaddr_q;
    assign o_MEMREQ  = memreq_q;
    assign o_PCDATA  = pcdata_q;
    assign o_PCWRITE = pcwrite_q;

endmodule
